// File: rtl/shift_reg_universal_if.sv
// Control, data and status bundle for the universal shift register.
// master drives mode/data, slave (the register) returns contents and frame status.
interface shift_reg_universal_if #(
  parameter int WIDTH = 4
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             en;
  logic [1:0]       mode;
  logic             rot;
  logic             s_in_r;
  logic             s_in_l;
  logic [WIDTH-1:0] p_in;
  logic [WIDTH-1:0] p_out;
  logic             s_out_r;
  logic             s_out_l;
  logic [CW-1:0]    cnt;
  logic             done;

  modport master (
    output en, mode, rot, s_in_r, s_in_l, p_in,
    input  p_out, s_out_r, s_out_l, cnt, done
  );

  modport slave (
    input  en, mode, rot, s_in_r, s_in_l, p_in,
    output p_out, s_out_r, s_out_l, cnt, done
  );
endinterface

// File: rtl/shift_reg_universal.sv
// WIDTH-bit universal shift register (hold / shift right / shift left / load / rotate)
// with a saturating shift counter and a one-cycle frame-done pulse for SERDES use.
module shift_reg_universal #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_reg_universal_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [WIDTH-1:0] q, q_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             done, done_nxt;

  // Counter sticks at WIDTH so done cannot re-fire until the next load or reset.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CNT_FULL) ? CNT_FULL : c + CW'(1);
  endfunction

  always_comb begin
    q_nxt    = q;
    cnt_nxt  = cnt;
    done_nxt = 1'b0;
    if (bus.en) begin
      case (bus.mode)
        MODE_RIGHT: begin
          q_nxt    = {(bus.rot ? q[0] : bus.s_in_r), q[WIDTH-1:1]};
          cnt_nxt  = sat_inc(cnt);
          done_nxt = (cnt == CNT_LAST);
        end
        MODE_LEFT: begin
          q_nxt    = {q[WIDTH-2:0], (bus.rot ? q[WIDTH-1] : bus.s_in_l)};
          cnt_nxt  = sat_inc(cnt);
          done_nxt = (cnt == CNT_LAST);
        end
        MODE_LOAD: begin
          q_nxt   = bus.p_in;
          cnt_nxt = '0;
        end
        MODE_HOLD: ;
        default: ;
      endcase
    end
  end

  // Register stage: contents, counter and pulse all clear asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q    <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      q    <= q_nxt;
      cnt  <= cnt_nxt;
      done <= done_nxt;
    end
  end

  assign bus.p_out   = q;
  assign bus.s_out_r = q[0];
  assign bus.s_out_l = q[WIDTH-1];
  assign bus.cnt     = cnt;
  assign bus.done    = done;

endmodule

// File: tb/tb_shift_reg_universal.sv
// Scoreboard bench for shift_reg_universal: stimulus pushes model predictions,
// a monitor pops one prediction per clock edge and compares against the outputs.
module tb_shift_reg_universal;
  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  typedef struct packed {
    logic [W-1:0]  q;
    logic [CW-1:0] cnt;
    logic          done;
  } exp_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   popped = 0;
  exp_t sb[$];

  // Reference state: bits as a vector, shifts since load as an unbounded integer.
  logic [W-1:0] m_q;
  int           m_shifts;
  logic         m_done;

  shift_reg_universal_if #(.WIDTH(W)) bus ();

  shift_reg_universal #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    e.q    = m_q;
    e.cnt  = CW'((m_shifts > W) ? W : m_shifts);
    e.done = m_done;
    return e;
  endfunction

  function automatic void model_edge(input logic en, input logic [1:0] mode, input logic rot,
                                     input logic sr, input logic sl, input logic [W-1:0] pin);
    logic b;
    m_done = 1'b0;
    if (en) begin
      if (mode == 2'd1) begin
        b        = rot ? m_q[0] : sr;
        m_q      = (m_q >> 1) | (W'(b) << (W - 1));
        m_shifts = m_shifts + 1;
        m_done   = (m_shifts == W);
      end else if (mode == 2'd2) begin
        b        = rot ? m_q[W-1] : sl;
        m_q      = (m_q << 1) | W'(b);
        m_shifts = m_shifts + 1;
        m_done   = (m_shifts == W);
      end else if (mode == 2'd3) begin
        m_q      = pin;
        m_shifts = 0;
      end
    end
  endfunction

  function automatic void model_reset();
    m_q      = '0;
    m_shifts = 0;
    m_done   = 1'b0;
  endfunction

  task automatic drive(input logic en, input logic [1:0] mode, input logic rot,
                       input logic sr, input logic sl, input logic [W-1:0] pin);
    bus.en     = en;
    bus.mode   = mode;
    bus.rot    = rot;
    bus.s_in_r = sr;
    bus.s_in_l = sl;
    bus.p_in   = pin;
  endtask

  task automatic step(input logic en, input logic [1:0] mode, input logic rot,
                      input logic sr, input logic sl, input logic [W-1:0] pin);
    @(negedge clk);
    drive(en, mode, rot, sr, sl, pin);
    model_edge(en, mode, rot, sr, sl, pin);
    sb.push_back(model_snapshot());
    pushed++;
  endtask

  // Reset pulse between edges; the following edge runs the given inputs normally.
  task automatic pulse_reset(input logic en, input logic [1:0] mode, input logic rot,
                             input logic sr, input logic sl, input logic [W-1:0] pin);
    @(negedge clk);
    drive(en, mode, rot, sr, sl, pin);
    #2 rst = 1'b0;
    #1;
    chk("rst_p_out",   32'(bus.p_out),   32'd0);
    chk("rst_s_out_r", 32'(bus.s_out_r), 32'd0);
    chk("rst_s_out_l", 32'(bus.s_out_l), 32'd0);
    chk("rst_cnt",     32'(bus.cnt),     32'd0);
    chk("rst_done",    32'(bus.done),    32'd0);
    #4 rst = 1'b1;
    model_reset();
    model_edge(en, mode, rot, sr, sl, pin);
    sb.push_back(model_snapshot());
    pushed++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        popped++;
        chk("p_out",   32'(bus.p_out),   32'(e.q));
        chk("s_out_r", 32'(bus.s_out_r), 32'(e.q[0]));
        chk("s_out_l", 32'(bus.s_out_l), 32'(e.q[W-1]));
        chk("cnt",     32'(bus.cnt),     32'(e.cnt));
        chk("done",    32'(bus.done),    32'(e.done));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout actual running required finished");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [1:0] md;
    int         r;
    rst = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, '0);
    model_reset();

    // Reset with live inputs; first edge after release is a load.
    pulse_reset(1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 4'b1011);

    // Serialise 1011 with five right shifts (fifth saturates).
    for (int i = 0; i < 5; i++) step(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 4'b0110);

    // Serial-in/serial-out from reset: 1,1,0,1 then flush with zeros.
    pulse_reset(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, '0);

    // Rotate left from 1000.
    step(1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 4'b1000);
    for (int i = 0; i < 4; i++) step(1'b1, 2'b10, 1'b1, 1'b1, 1'b0, '0);

    // Stall with X mode, then hold, then resume to done.
    step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 4'b0110);
    step(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 3; i++) step(1'b0, 2'bxx, 1'b1, 1'b1, 1'b1, 4'b1111);
    for (int i = 0; i < 2; i++) step(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 4'b1111);
    step(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, '0);

    // Abort mid-frame, then load on the would-be WIDTH-th shift.
    step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 4'b1111);
    step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, '0);
    pulse_reset(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, '0);
    step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 4'b0101);
    step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, '0);

    // Randomised traffic, biased toward shifts so frames complete.
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 10)      md = 2'b11;
      else if (r < 18) md = 2'b00;
      else if (r < 59) md = 2'b01;
      else             md = 2'b10;
      if ($urandom_range(0, 59) == 0) begin
        pulse_reset(1'($urandom), md, 1'($urandom), 1'($urandom), 1'($urandom), W'($urandom));
      end else if ($urandom_range(0, 9) == 0) begin
        step(1'b0, ($urandom_range(0, 1) == 0) ? 2'bxx : md, 1'($urandom),
             1'($urandom), 1'($urandom), W'($urandom));
      end else begin
        step(1'b1, md, 1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), W'($urandom));
      end
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(popped), 32'(pushed));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_reg_universal.md
Name: shift_reg_universal

Overview:
Parametrised universal shift register. It generalises the 4-bit fixed serial-in/serial-out register to WIDTH bits. It supports hold, shift right, shift left, parallel load and rotate. A shift counter and a frame-done pulse let it act as a serialiser or deserialiser in the sequential-circuits library, e.g. between a parallel datapath and a 1-bit link.

Parameters:
WIDTH, 4, register length in bits; legal values are WIDTH >= 2.
CW, $clog2(WIDTH+1), shift-counter width; derived, not to be overridden.

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset
en  input  1  clock enable; 0 = hold everything
mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
rot  input  1  1 = rotate (the outgoing bit re-enters) instead of taking serial input
s_in_r  input  1  serial input for a right shift; enters the MSB
s_in_l  input  1  serial input for a left shift; enters the LSB
p_in  input  WIDTH  parallel load data
p_out  output  WIDTH  register contents q
s_out_r  output  1  q[0], the right-shift serial output
s_out_l  output  1  q[WIDTH-1], the left-shift serial output
cnt  output  CW  shifts since the last load or reset; saturates at WIDTH
done  output  1  one-cycle pulse when cnt reaches WIDTH

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- rst=0 forces the following immediately, with no clock edge required, and holds them while rst=0: q=0, cnt=0, done=0. Consequently p_out=0, s_out_r=0 and s_out_l=0.
- Outputs p_out, s_out_r and s_out_l are combinational from q. cnt and done are registered.
- Every edge with en=1 does the following by mode:
  - 00: q and cnt held; done<=0.
  - 01: q<={ (rot ? q[0] : s_in_r), q[WIDTH-1:1] }.
  - 10: q<={ q[WIDTH-2:0], (rot ? q[WIDTH-1] : s_in_l) }.
  - 11: q<=p_in; cnt<=0; done<=0; rot is ignored.
- Shift modes (01, 10) update the counter as well:
  - cnt<=(cnt==WIDTH) ? WIDTH : cnt+1.
  - done<=(cnt==WIDTH-1).
- The counter counts total shifts regardless of direction. Mixing left and right shifts within a frame still advances cnt.
- done is high for exactly one cycle, after the edge on which cnt goes from WIDTH-1 to WIDTH.
  - done does not re-fire while cnt is saturated.
  - A new frame needs a load (mode 11) or a reset.
  - After reset with no load, WIDTH shifts also produce done.
- Edge with en=0: q and cnt held; done<=0. The pulse is never stretched by a stall.
- Latency:
  - A bit driven on s_in_r before edge k appears on s_out_r after edge k+WIDTH-1, i.e. after WIDTH shifting edges. Left shift is symmetrical.
  - Parallel-to-serial: after a load, s_out_r shows p_in[0], then p_in[1], and so on, one bit per shift edge.
- Boundary conditions:
  - Reset asserted mid-frame clears cnt, and done does not fire for the aborted frame.
  - Reset released: the first edge with rst=1 operates normally.
  - Load on the same edge as what would be the WIDTH-th shift: the load wins, so cnt=0 and done=0.
  - Inputs s_in_r and s_in_l are ignored in modes other than their shift direction, and in rotate.
  - X on mode while en=0 must not corrupt state.

Test Plan:
- Reset: apply inputs, drive rst=0 mid-cycle -> p_out=4'b0000, s_out_r=0, cnt=0 and done=0 immediately, before any clock edge.
- Serialise (WIDTH=4): load p_in=4'b1011, then 4 right shifts with s_in_r=0 -> p_out goes 1011, 0101, 0010, 0001, 0000; s_out_r goes 1, 1, 0, 1; cnt goes 0, 1, 2, 3, 4; done=1 for exactly one cycle after the 4th shift; a 5th shift keeps cnt=4 and done=0.
- Serial-in/serial-out: after reset, shift right with s_in_r sequence 1, 1, 0, 1 -> p_out=4'b1011 after 4 edges; s_out_r then emits 1, 1, 0, 1 on the next 4 edges with s_in_r=0.
- Rotate left: load 4'b1000, mode=10, rot=1, s_in_l=0 -> p_out goes 0001, 0010, 0100, 1000; done pulses after the 4th edge; no bit is lost.
- Stall and hold: mid-frame at cnt=2, set en=0 for 3 cycles, then mode=00 for 2 cycles -> p_out and cnt unchanged and done=0 throughout; resuming the shift reaches done after 2 more shifts.
- Abort: load 4'b1111, shift twice, pulse rst low for 5 ns between edges -> q=0 and cnt=0 asynchronously; 2 further shifts give cnt=2 and no done; a load on the would-be 4th shift edge gives cnt=0 and done=0.
